// File: rtl/instr_fifo_pkg.sv
// Package for the instruction queue.
// Holds the TPU instruction field widths, the decoded instruction struct
// and the helper that splits a flat instruction word into its fields.
// Field order, MSB -> LSB: buffer_addr, acc_addr, length, opcode.
package instr_fifo_pkg;

    localparam int BUFFER_ADDR_WIDTH = 24;
    localparam int ACC_ADDR_WIDTH    = 16;
    localparam int LENGTH_WIDTH      = 32;
    localparam int OPCODE_WIDTH      = 8;
    localparam int INSTR_WIDTH       = BUFFER_ADDR_WIDTH + ACC_ADDR_WIDTH
                                     + LENGTH_WIDTH + OPCODE_WIDTH;

    typedef struct packed {
        logic [BUFFER_ADDR_WIDTH-1:0] buffer_addr;
        logic [ACC_ADDR_WIDTH-1:0]    acc_addr;
        logic [LENGTH_WIDTH-1:0]      length;
        logic [OPCODE_WIDTH-1:0]      opcode;
    } instr_type;

    // Number of host bus beats needed to carry one instruction.
    function automatic int num_beats(input int instr_w, input int bus_w);
        return (instr_w + bus_w - 1) / bus_w;
    endfunction

    // Split a flat instruction word into named fields; opcode sits in the LSBs.
    function automatic instr_type bit_to_instr(input logic [INSTR_WIDTH-1:0] bits);
        instr_type r;
        r.opcode      = bits[OPCODE_WIDTH-1:0];
        r.length      = bits[OPCODE_WIDTH +: LENGTH_WIDTH];
        r.acc_addr    = bits[OPCODE_WIDTH+LENGTH_WIDTH +: ACC_ADDR_WIDTH];
        r.buffer_addr = bits[OPCODE_WIDTH+LENGTH_WIDTH+ACC_ADDR_WIDTH +: BUFFER_ADDR_WIDTH];
        return r;
    endfunction

endpackage

// File: rtl/instr_fifo_sync_fifo.sv
// sync_fifo: generic first-word-fall-through queue.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   flush           sync clear of pointers and count (wins over push/pop)
//   push, wr_data   write request and data; refused when full unless a pop
//                   happens in the same cycle
//   pop             read request; ignored when empty
//   rd_data         entry at the read pointer (combinational)
//   count, full, empty  occupancy status
module sync_fifo #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    import instr_fifo_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A pop frees a slot in the same cycle, so a full queue can still take a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is data only; an unwritten slot is never visible because the
    // read side is gated by count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/instr_fifo.sv
// instr_fifo: assembles host bus beats into TPU instructions and queues them
// for the control unit's decoder.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   flush        sync clear of queue, staging beats and overflow flag
//   wr_en        host beat write strobe
//   wr_sel       beat index (0 = least significant); the top beat pushes
//   wr_data      beat data
//   out_valid    head instruction available
//   out_ready    consumer accepts the head this cycle
//   out_instr    head instruction split into fields (zero when empty)
//   count        occupied entries
//   full, empty  occupancy flags
//   overflow     sticky, set when a push was dropped because the queue was full
// The field width parameters must match the widths of instr_type in the package.
module instr_fifo
    import instr_fifo_pkg::*;
#(
    parameter int DEPTH             = 32,
    parameter int BUS_WIDTH         = 32,
    parameter int BUFFER_ADDR_WIDTH = instr_fifo_pkg::BUFFER_ADDR_WIDTH,
    parameter int ACC_ADDR_WIDTH    = instr_fifo_pkg::ACC_ADDR_WIDTH,
    parameter int LENGTH_WIDTH      = instr_fifo_pkg::LENGTH_WIDTH,
    parameter int OPCODE_WIDTH      = instr_fifo_pkg::OPCODE_WIDTH,
    parameter int INSTR_W   = BUFFER_ADDR_WIDTH + ACC_ADDR_WIDTH + LENGTH_WIDTH + OPCODE_WIDTH,
    parameter int NUM_BEATS = num_beats(INSTR_W, BUS_WIDTH),
    parameter int SEL_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [SEL_W-1:0]           wr_sel,
    input  logic [BUS_WIDTH-1:0]       wr_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output instr_type                  out_instr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    // Staging holds beats 0..NUM_BEATS-2; at least one slot so the vector is never empty.
    localparam int STG_N  = (NUM_BEATS > 1) ? NUM_BEATS - 1 : 1;
    localparam int FULL_W = NUM_BEATS * BUS_WIDTH;

    logic [STG_N*BUS_WIDTH-1:0] staging;
    logic [FULL_W-1:0]          beats_flat;
    logic [INSTR_W-1:0]         rd_bits;
    logic                       push_req;
    logic                       pop_req;

    // Writing the top beat completes the instruction; out-of-range indices do nothing.
    assign push_req = wr_en && (wr_sel == SEL_W'(NUM_BEATS - 1));
    assign pop_req  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging <= '0;
        end else if (flush) begin
            staging <= '0;
        end else begin
            for (int i = 0; i < STG_N; i++) begin
                if (wr_en && (int'(wr_sel) == i) && (i < NUM_BEATS - 1))
                    staging[i*BUS_WIDTH +: BUS_WIDTH] <= wr_data;
            end
        end
    end

    // The top beat is taken straight from the bus so the push needs no extra cycle.
    always_comb begin
        beats_flat = '0;
        for (int i = 0; i < NUM_BEATS - 1; i++)
            beats_flat[i*BUS_WIDTH +: BUS_WIDTH] = staging[i*BUS_WIDTH +: BUS_WIDTH];
        beats_flat[(NUM_BEATS-1)*BUS_WIDTH +: BUS_WIDTH] = wr_data;
    end

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .push    (push_req),
        .wr_data (beats_flat[INSTR_W-1:0]),
        .pop     (pop_req),
        .rd_data (rd_bits),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign out_valid = !empty;
    assign out_instr = empty ? '0 : bit_to_instr(rd_bits);

    // A push into a full queue survives only when the head leaves in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (push_req && full && !pop_req) begin
            overflow <= 1'b1;
        end
    end

endmodule
